// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   state_e  : control FSM states, also driven out on o_state
//   fw_sel_e : ALU operand source select
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LSTALL = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      FW_REG   = 2'b00,
      FW_EXMEM = 2'b01,
      FW_MEMWB = 2'b10
   } fw_sel_e;

   // Width of the load-stall / drain sequencing counter.
   localparam int unsigned NB_SEQ = 8;

endpackage

// File: rtl/fw_select.sv
// Forwarding select for one ALU operand.
//   i_src                   : source register of the EX instruction
//   i_rd_mem/i_regWrite_mem : EX/MEM destination and write enable
//   i_rd_wb/i_regWrite_wb   : MEM/WB destination and write enable
//   o_fw                    : 00 regfile, 01 EX/MEM, 10 MEM/WB
module fw_select
   import hazard_pkg::*;
#(
   parameter int unsigned NB_ADDR = 5
) (
   input  logic [NB_ADDR-1:0] i_src,
   input  logic [NB_ADDR-1:0] i_rd_mem,
   input  logic               i_regWrite_mem,
   input  logic [NB_ADDR-1:0] i_rd_wb,
   input  logic               i_regWrite_wb,
   output logic [1:0]         o_fw
);

   // EX/MEM holds the younger result, so it is checked last and wins.
   always_comb begin
      o_fw = FW_REG;
      if (i_regWrite_wb && (i_rd_wb != '0) && (i_rd_wb == i_src)) begin
         o_fw = FW_MEMWB;
      end
      if (i_regWrite_mem && (i_rd_mem != '0) && (i_rd_mem == i_src)) begin
         o_fw = FW_EXMEM;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard and pipeline control for the 5-stage core.
//   Inputs : ID/EX/MEM/WB register addresses and write/load flags, jump, halt, resume
//   Outputs: o_fw_a/o_fw_b operand selects; o_stall_pc, o_stall_ifid, o_bubble_idex,
//            o_flush_ifid stage strobes; o_halted, o_state; o_stall_cnt load-use
//            stall statistics (saturating).
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned NB_ADDR   = 5,
   parameter int unsigned NB_STAGES = 5,
   parameter int unsigned LOAD_LAT  = 1,
   parameter int unsigned NB_CNT    = 16
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic [NB_ADDR-1:0] i_rs_id,
   input  logic [NB_ADDR-1:0] i_rt_id,
   input  logic               i_uses_rs,
   input  logic               i_uses_rt,
   input  logic [NB_ADDR-1:0] i_rs_ex,
   input  logic [NB_ADDR-1:0] i_rt_ex,
   input  logic [NB_ADDR-1:0] i_rd_ex,
   input  logic               i_regWrite_ex,
   input  logic               i_memRead_ex,
   input  logic [NB_ADDR-1:0] i_rd_mem,
   input  logic               i_regWrite_mem,
   input  logic [NB_ADDR-1:0] i_rd_wb,
   input  logic               i_regWrite_wb,
   input  logic               i_jump_id,
   input  logic               i_halt_id,
   input  logic               i_resume,
   output logic               o_stall_pc,
   output logic               o_stall_ifid,
   output logic               o_bubble_idex,
   output logic               o_flush_ifid,
   output logic [1:0]         o_fw_a,
   output logic [1:0]         o_fw_b,
   output logic               o_halted,
   output logic [1:0]         o_state,
   output logic [NB_CNT-1:0]  o_stall_cnt
);

   state_e              state_q, state_d;
   logic [NB_SEQ-1:0]   seq_q, seq_d;
   logic [NB_CNT-1:0]   stall_cnt_q, stall_cnt_d;

   logic [1:0] fw_a, fw_b;
   logic       lu_hit;
   logic       hold;
   logic       flush;
   logic       lu_stall;

   fw_select #(.NB_ADDR(NB_ADDR)) u_fw_a (
      .i_src          (i_rs_ex),
      .i_rd_mem       (i_rd_mem),
      .i_regWrite_mem (i_regWrite_mem),
      .i_rd_wb        (i_rd_wb),
      .i_regWrite_wb  (i_regWrite_wb),
      .o_fw           (fw_a)
   );

   fw_select #(.NB_ADDR(NB_ADDR)) u_fw_b (
      .i_src          (i_rt_ex),
      .i_rd_mem       (i_rd_mem),
      .i_regWrite_mem (i_regWrite_mem),
      .i_rd_wb        (i_rd_wb),
      .i_regWrite_wb  (i_regWrite_wb),
      .o_fw           (fw_b)
   );

   // Only operands the ID instruction really reads can create a load-use hazard.
   always_comb begin
      lu_hit = i_memRead_ex && i_regWrite_ex && (i_rd_ex != '0) &&
               ((i_uses_rs && (i_rs_id == i_rd_ex)) ||
                (i_uses_rt && (i_rt_id == i_rd_ex)));
   end

   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      stall_cnt_d = stall_cnt_q;
      hold        = 1'b0;
      flush       = 1'b0;
      lu_stall    = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (lu_hit) begin
               hold     = 1'b1;
               lu_stall = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_d = ST_LSTALL;
                  seq_d   = NB_SEQ'(LOAD_LAT - 1);
               end
            end else if (i_halt_id) begin
               state_d = ST_DRAIN;
               seq_d   = NB_SEQ'(NB_STAGES - 2);
            end else begin
               flush = i_jump_id;
            end
         end
         ST_LSTALL: begin
            // A jump seen here is re-presented once ID unstalls.
            hold     = 1'b1;
            lu_stall = 1'b1;
            seq_d    = seq_q - NB_SEQ'(1);
            if (seq_q <= NB_SEQ'(1)) begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // HALT stays parked in IF/ID while older instructions retire.
            hold  = 1'b1;
            seq_d = seq_q - NB_SEQ'(1);
            if (seq_q <= NB_SEQ'(1)) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            hold = 1'b1;
            if (i_resume) begin
               // Drop the parked HALT; PC already points past it.
               flush   = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (lu_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + NB_CNT'(1);
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_RUN;
         seq_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Combinational outputs are forced low while reset is held.
   always_comb begin
      o_stall_pc    = hold & i_rst_n;
      o_stall_ifid  = hold & i_rst_n;
      o_bubble_idex = hold & i_rst_n;
      o_flush_ifid  = flush & i_rst_n;
      o_fw_a        = i_rst_n ? fw_a : FW_REG;
      o_fw_b        = i_rst_n ? fw_b : FW_REG;
      o_halted      = (state_q == ST_HALTED) & i_rst_n;
      o_state       = state_q;
      o_stall_cnt   = stall_cnt_q;
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int NB_ADDR   = 5;
   localparam int NB_STAGES = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NB_ADDR-1:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
   logic uses_rs, uses_rt, rw_ex, mr_ex, rw_mem, rw_wb, jump, halt, resume;

   // Two instances: LOAD_LAT=1 with a tiny counter, LOAD_LAT=3 with the default counter.
   logic       spc [2], sif [2], bub [2], fl [2], hlt [2];
   logic [1:0] fwa [2], fwb [2], st [2];
   logic [3:0]  cnt_a;
   logic [15:0] cnt_b;

   pipeline_hazard_ctrl #(.NB_ADDR(NB_ADDR), .NB_STAGES(NB_STAGES), .LOAD_LAT(1), .NB_CNT(4))
   u_dut_a (
      .clk(clk), .i_rst_n(rst_n), .i_rs_id(rs_id), .i_rt_id(rt_id), .i_uses_rs(uses_rs),
      .i_uses_rt(uses_rt), .i_rs_ex(rs_ex), .i_rt_ex(rt_ex), .i_rd_ex(rd_ex),
      .i_regWrite_ex(rw_ex), .i_memRead_ex(mr_ex), .i_rd_mem(rd_mem), .i_regWrite_mem(rw_mem),
      .i_rd_wb(rd_wb), .i_regWrite_wb(rw_wb), .i_jump_id(jump), .i_halt_id(halt),
      .i_resume(resume), .o_stall_pc(spc[0]), .o_stall_ifid(sif[0]), .o_bubble_idex(bub[0]),
      .o_flush_ifid(fl[0]), .o_fw_a(fwa[0]), .o_fw_b(fwb[0]), .o_halted(hlt[0]),
      .o_state(st[0]), .o_stall_cnt(cnt_a)
   );

   pipeline_hazard_ctrl #(.NB_ADDR(NB_ADDR), .NB_STAGES(NB_STAGES), .LOAD_LAT(3), .NB_CNT(16))
   u_dut_b (
      .clk(clk), .i_rst_n(rst_n), .i_rs_id(rs_id), .i_rt_id(rt_id), .i_uses_rs(uses_rs),
      .i_uses_rt(uses_rt), .i_rs_ex(rs_ex), .i_rt_ex(rt_ex), .i_rd_ex(rd_ex),
      .i_regWrite_ex(rw_ex), .i_memRead_ex(mr_ex), .i_rd_mem(rd_mem), .i_regWrite_mem(rw_mem),
      .i_rd_wb(rd_wb), .i_regWrite_wb(rw_wb), .i_jump_id(jump), .i_halt_id(halt),
      .i_resume(resume), .o_stall_pc(spc[1]), .o_stall_ifid(sif[1]), .o_bubble_idex(bub[1]),
      .o_flush_ifid(fl[1]), .o_fw_a(fwa[1]), .o_fw_b(fwb[1]), .o_halted(hlt[1]),
      .o_state(st[1]), .o_stall_cnt(cnt_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: remaining bubble cycles, remaining drain cycles, halted flag,
   // stall statistics. Next values are computed at the sample point, applied at the edge.
   int lat [2]  = '{1, 3};
   int cmax [2] = '{15, 65535};
   int m_ls [2], m_dr [2], m_h [2], m_cnt [2];
   int n_ls [2], n_dr [2], n_h [2], n_cnt [2];

   function automatic logic [1:0] fwd(input logic [NB_ADDR-1:0] src);
      if (rw_mem && rd_mem != 0 && rd_mem == src) return 2'b01;
      if (rw_wb && rd_wb != 0 && rd_wb == src) return 2'b10;
      return 2'b00;
   endfunction

   task automatic eval_check(input int d);
      logic hit, hold, flush, halted, count;
      int   state;
      logic [31:0] cnt_now;
      hit = mr_ex && rw_ex && rd_ex != 0 &&
            ((uses_rs && rs_id == rd_ex) || (uses_rt && rt_id == rd_ex));
      hold = 0; flush = 0; halted = 0; count = 0; state = 0;
      if (!rst_n) begin
         m_ls[d] = 0; m_dr[d] = 0; m_h[d] = 0; m_cnt[d] = 0;
      end
      n_ls[d] = m_ls[d]; n_dr[d] = m_dr[d]; n_h[d] = m_h[d];
      if (!rst_n) begin
         // everything idle
      end else if (m_h[d] != 0) begin
         hold = 1; halted = 1; state = 3;
         if (resume) begin flush = 1; n_h[d] = 0; end
      end else if (m_dr[d] > 0) begin
         hold = 1; state = 2; n_dr[d] = m_dr[d] - 1;
         if (n_dr[d] == 0) n_h[d] = 1;
      end else if (m_ls[d] > 0) begin
         hold = 1; state = 1; count = 1; n_ls[d] = m_ls[d] - 1;
      end else if (hit) begin
         hold = 1; count = 1; n_ls[d] = lat[d] - 1;
      end else if (halt) begin
         n_dr[d] = NB_STAGES - 2;
      end else begin
         flush = jump;
      end
      n_cnt[d] = (count && m_cnt[d] < cmax[d]) ? m_cnt[d] + 1 : m_cnt[d];
      cnt_now = (d == 0) ? 32'(cnt_a) : 32'(cnt_b);
      check($sformatf("fw%0d", d), {fwa[d], fwb[d]},
            rst_n ? {fwd(rs_ex), fwd(rt_ex)} : 4'b0);
      check($sformatf("strobes%0d", d), {spc[d], sif[d], bub[d], fl[d], hlt[d]},
            {hold, hold, hold, flush, halted});
      check($sformatf("state%0d", d), st[d], state);
      check($sformatf("cnt%0d", d), cnt_now, m_cnt[d]);
   endtask

   task automatic step();
      @(negedge clk);
      for (int d = 0; d < 2; d++) eval_check(d);
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         m_ls[d] = n_ls[d]; m_dr[d] = n_dr[d]; m_h[d] = n_h[d]; m_cnt[d] = n_cnt[d];
      end
      #1;
   endtask

   task automatic idle();
      {rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb} = '0;
      {uses_rs, uses_rt, rw_ex, mr_ex, rw_mem, rw_wb, jump, halt, resume} = '0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      step();
      rst_n = 1;
   endtask

   task automatic load_use_r2();
      idle();
      mr_ex = 1; rw_ex = 1; rd_ex = 5'd2; rs_id = 5'd2; uses_rs = 1;
   endtask

   initial begin
      idle();
      step();
      check("reset_state", st[1], 0);
      check("reset_halted", hlt[0], 0);
      rst_n = 1;

      // Forwarding: MEM and WB both hold r3 -> EX/MEM; WB only -> MEM/WB; r0 -> regfile.
      rd_mem = 5'd3; rw_mem = 1; rd_wb = 5'd3; rw_wb = 1; rs_ex = 5'd3; rt_ex = 5'd7;
      #1 check("fw_a_exmem", fwa[0], 2'b01);
      check("fw_b_none", fwb[0], 2'b00);
      step();
      rw_mem = 0;
      #1 check("fw_a_memwb", fwa[0], 2'b10);
      step();
      rd_wb = 5'd0; rd_mem = 5'd0; rw_mem = 1; rs_ex = 5'd0;
      #1 check("fw_a_r0", fwa[0], 2'b00);
      step();

      // Load-use: LOAD_LAT=1 -> one stall cycle; LOAD_LAT=3 -> three, two in LSTALL.
      do_reset();
      load_use_r2();
      step();
      check("lu_state_b", st[1], 1);
      idle();
      step();
      step();
      check("lu_cnt_a", cnt_a, 1);
      check("lu_cnt_b", cnt_b, 3);
      check("lu_done_b", st[1], 0);

      // rt matches but is unused -> no stall.
      idle();
      mr_ex = 1; rw_ex = 1; rd_ex = 5'd2; rt_id = 5'd2; uses_rt = 0;
      #1 check("no_lu_stall", spc[1], 0);
      step();

      // Jump alone flushes; jump plus load-use stalls only.
      idle(); jump = 1;
      #1 check("jump_flush", fl[0], 1);
      step();
      load_use_r2(); jump = 1;
      #1 check("jump_lu_noflush", fl[0], 0);
      check("jump_lu_stall", spc[0], 1);
      step();
      idle(); step(); step();

      // Halt: three drain cycles, then halted; resume flushes and returns to RUN.
      idle(); halt = 1;
      step();
      idle();
      for (int i = 0; i < NB_STAGES - 2; i++) step();
      check("halted_state", st[0], 3);
      check("halted_flag", hlt[1], 1);
      step();
      resume = 1;
      #1 check("resume_flush", fl[0], 1);
      step();
      resume = 0;
      check("resume_run", st[0], 0);

      // Reset during the second drain cycle.
      idle(); halt = 1;
      step();
      idle();
      step();
      rst_n = 0;
      #1 check("rst_drain_state", st[0], 0);
      check("rst_drain_halted", hlt[0], 0);
      check("rst_drain_stall", spc[1], 0);
      step();
      rst_n = 1;

      // Continuous load-use saturates the 4-bit counter.
      load_use_r2();
      for (int i = 0; i < 20; i++) step();
      check("sat_cnt_a", cnt_a, 4'hf);
      idle(); step(); step();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rs_id  = NB_ADDR'($urandom_range(0, 3));
         rt_id  = NB_ADDR'($urandom_range(0, 3));
         rs_ex  = NB_ADDR'($urandom_range(0, 3));
         rt_ex  = NB_ADDR'($urandom_range(0, 3));
         rd_ex  = NB_ADDR'($urandom_range(0, 3));
         rd_mem = NB_ADDR'($urandom_range(0, 3));
         rd_wb  = NB_ADDR'($urandom_range(0, 3));
         uses_rs = 1'($urandom_range(0, 1));
         uses_rt = 1'($urandom_range(0, 1));
         rw_ex   = ($urandom_range(0, 3) != 0);
         mr_ex   = ($urandom_range(0, 2) == 0);
         rw_mem  = 1'($urandom_range(0, 1));
         rw_wb   = 1'($urandom_range(0, 1));
         jump    = ($urandom_range(0, 3) == 0);
         halt    = ($urandom_range(0, 15) == 0);
         resume  = ($urandom_range(0, 3) == 0);
         rst_n   = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
